// File: rtl/sd_bram_port_arb_if.sv
// Signal bundle between the two port-A requesters, the arbiter and the
// BRAM port A. The arbiter connects through the slave modport; the
// requester/BRAM side (or a bench) uses the master modport.

interface sd_bram_port_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36
);

  // Requester 0: SD command/data engine
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvld0;
  logic [DATA_W-1:0] rdata0;

  // Requester 1: host register/DMA path
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvld1;
  logic [DATA_W-1:0] rdata1;

  // BRAM port A
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_wr;
  logic [DATA_W-1:0] bram_dout;

  // Arbiter status
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output bram_dout,
    input  gnt0, rvld0, rdata0,
    input  gnt1, rvld1, rdata1,
    input  bram_addr, bram_din, bram_wr,
    input  busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  bram_dout,
    output gnt0, rvld0, rdata0,
    output gnt1, rvld1, rdata1,
    output bram_addr, bram_din, bram_wr,
    output busy
  );

endinterface

// File: rtl/sd_bram_port_arb.sv
// sd_bram_port_arb: two-requester round-robin arbiter for port A of the
// SD-card 512x36 dual-port block-RAM buffer. Requester 0 is the SD
// command/data engine, requester 1 the host register/DMA path. A cycle in
// which the owner keeps its request high is one beat driven straight onto
// the BRAM port; read beats return data one cycle later together with a
// per-requester valid strobe. A burst is capped at MAX_BURST beats only
// while the other requester is waiting (MAX_BURST legal range 1..256).

module sd_bram_port_arb #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 36,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  sd_bram_port_arb_if.slave bus
);

  // The counter only has to reach MAX_BURST-1; keep at least one bit so that
  // MAX_BURST=1 still elaborates (the counter then stays at zero and every
  // contested beat hands the port over).
  localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              last_owner_r;
  logic              last_owner_s;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [CNT_W-1:0]  beat_cnt_s;

  logic              own_id_s;
  logic              own_req_s;
  logic              oth_req_s;
  logic              beat0_s;
  logic              beat1_s;

  logic              rvld0_r;
  logic              rvld1_r;

  logic [ADDR_W-1:0] bram_addr_s;
  logic [DATA_W-1:0] bram_din_s;
  logic              bram_wr_s;

  // Ownership state for a given requester index.
  function automatic state_t own_state(input logic owner);
    state_t st;
    if (owner) begin
      st = ST_OWN1;
    end else begin
      st = ST_OWN0;
    end
    return st;
  endfunction

  // Winner of a simultaneous request from IDLE: whoever did not own last.
  function automatic logic contest_winner(input logic last_owner);
    return ~last_owner;
  endfunction

  // Current owner index and the request lines seen from the owner's side.
  always_comb begin
    own_id_s  = (state_r == ST_OWN1);
    own_req_s = 1'b0;
    oth_req_s = 1'b0;
    if (own_id_s) begin
      own_req_s = bus.req1;
      oth_req_s = bus.req0;
    end else begin
      own_req_s = bus.req0;
      oth_req_s = bus.req1;
    end
  end

  // Beat qualification: the owner is requesting in a granted cycle.
  always_comb begin
    beat0_s = (state_r == ST_OWN0) && bus.req0;
    beat1_s = (state_r == ST_OWN1) && bus.req1;
  end

  // Next-state logic: arbitration from IDLE, release, fairness handover and
  // beat counting (the counter clears on every state change).
  always_comb begin
    state_s      = state_r;
    last_owner_s = last_owner_r;
    beat_cnt_s   = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        beat_cnt_s = '0;
        if (bus.req0 && bus.req1) begin
          state_s = own_state(contest_winner(last_owner_r));
        end else if (bus.req0) begin
          state_s = ST_OWN0;
        end else if (bus.req1) begin
          state_s = ST_OWN1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req_s) begin
          // Owner released: no beat this cycle, hand over directly if the
          // other side is waiting so the port never idles between owners.
          last_owner_s = own_id_s;
          beat_cnt_s   = '0;
          if (oth_req_s) begin
            state_s = own_state(~own_id_s);
          end else begin
            state_s = ST_IDLE;
          end
        end else if (beat_cnt_r == CNT_LAST) begin
          if (oth_req_s) begin
            // Fairness limit reached while the other side waits: this beat
            // completes, then the port moves over.
            last_owner_s = own_id_s;
            beat_cnt_s   = '0;
            state_s      = own_state(~own_id_s);
          end else begin
            // Uncontested: keep streaming, counter saturates.
            beat_cnt_s = beat_cnt_r;
            state_s    = state_r;
          end
        end else begin
          beat_cnt_s = beat_cnt_r + CNT_W'(1);
          state_s    = state_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        beat_cnt_s = '0;
      end
    endcase
  end

  // Arbitration state registers; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_owner_r <= 1'b1;
      beat_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      last_owner_r <= last_owner_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

  // BRAM port-A drive: the owner's beat goes straight to the port; outside
  // a beat the write strobe is held low and address/data are don't-care.
  always_comb begin
    bram_addr_s = bus.addr0;
    bram_din_s  = bus.wdata0;
    bram_wr_s   = 1'b0;
    if (state_r == ST_OWN1) begin
      bram_addr_s = bus.addr1;
      bram_din_s  = bus.wdata1;
      bram_wr_s   = beat1_s && bus.we1;
    end else begin
      bram_addr_s = bus.addr0;
      bram_din_s  = bus.wdata0;
      bram_wr_s   = beat0_s && bus.we0;
    end
  end

  // Read-valid strobes track the BRAM's one-cycle read latency and always
  // go to the requester that issued the read, even across a handover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvld0_r <= 1'b0;
      rvld1_r <= 1'b0;
    end else begin
      rvld0_r <= beat0_s && !bus.we0;
      rvld1_r <= beat1_s && !bus.we1;
    end
  end

  assign bus.gnt0      = (state_r == ST_OWN0);
  assign bus.gnt1      = (state_r == ST_OWN1);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.rvld0     = rvld0_r;
  assign bus.rvld1     = rvld1_r;
  assign bus.rdata0    = bus.bram_dout;
  assign bus.rdata1    = bus.bram_dout;
  assign bus.bram_addr = bram_addr_s;
  assign bus.bram_din  = bram_din_s;
  assign bus.bram_wr   = bram_wr_s;

  sd_bram_port_arb_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .gnt0    (bus.gnt0),
    .gnt1    (bus.gnt1),
    .busy    (bus.busy),
    .bram_wr (bus.bram_wr),
    .rvld0   (bus.rvld0),
    .rvld1   (bus.rvld1)
  );

endmodule

// Structural invariants of the arbiter outputs.
module sd_bram_port_arb_chk (
  input logic clk,
  input logic reset,
  input logic gnt0,
  input logic gnt1,
  input logic busy,
  input logic bram_wr,
  input logic rvld0,
  input logic rvld1
);

  a_gnt_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(gnt0 && gnt1));

  a_busy_matches_gnt: assert property (@(posedge clk) disable iff (reset)
    busy == (gnt0 || gnt1));

  a_wr_needs_gnt: assert property (@(posedge clk) disable iff (reset)
    bram_wr |-> (gnt0 || gnt1));

  a_rvld_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(rvld0 && rvld1));

endmodule

// File: tb/tb_sd_bram_port_arb.sv
// Bench for sd_bram_port_arb: directed scenarios plus randomized traffic.
// Two requester models follow the beat contract, a BRAM model with 1-cycle
// write-first read sits on port A, and a reference memory predicts every
// read return. Arbitration is judged from per-cycle logs of beat owners.

module tb_sd_bram_port_arb;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 36;
  localparam int MAX_BURST = 16;
  localparam int DEPTH     = 512;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sd_bram_port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sd_bram_port_arb #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Deterministic initial memory image; word 5 carries a known pattern.
  function automatic logic [DATA_W-1:0] seed_word(input int i);
    logic [DATA_W-1:0] v;
    v = DATA_W'(i) * 36'h0_9E37_79B1;
    v = v ^ 36'hA_5A5A_5A5A;
    if (i == 5) v = 36'h1_2345_6789;
    return v;
  endfunction

  // BRAM port-A model: registered output, write-first, reloaded in reset.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_r;
  assign bus.bram_dout = dout_r;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
      dout_r <= '0;
    end else if (bus.bram_wr) begin
      mem[bus.bram_addr] <= bus.bram_din;
      dout_r             <= bus.bram_din;
    end else begin
      dout_r <= mem[bus.bram_addr];
    end
  end

  // Reference state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int tests = 0;
  int fails = 0;

  // Requester models
  int                left  [2];
  logic              cwe   [2];
  logic [ADDR_W-1:0] caddr [2];
  logic [DATA_W-1:0] cwd   [2];
  bit                rd_only;
  int                wr_pct;
  int                run   [2];
  logic              pend  [2];
  logic [DATA_W-1:0] pdat  [2];

  int   log_q[$];   // beat owner per cycle (-1 = no beat)
  int   gnt_q[$];   // {gnt1,gnt0} per cycle
  int   rv_q[$];    // requester index of each rvld pulse in order

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic new_op(input int r);
    logic [DATA_W-1:0] w;
    w[31:0]        = $urandom();
    w[DATA_W-1:32] = 4'($urandom_range(15, 0));
    cwd[r]   = w;
    caddr[r] = ADDR_W'($urandom_range(DEPTH - 1, 0));
    cwe[r]   = rd_only ? 1'b0 : ($urandom_range(99, 0) < wr_pct);
  endtask

  task automatic apply();
    bus.req0   = (left[0] > 0);
    bus.we0    = cwe[0];
    bus.addr0  = caddr[0];
    bus.wdata0 = cwd[0];
    bus.req1   = (left[1] > 0);
    bus.we1    = cwe[1];
    bus.addr1  = caddr[1];
    bus.wdata1 = cwd[1];
  endtask

  // One clock of traffic. Entered at posedge+1 with inputs applied.
  task automatic cycle_step();
    logic b [2];
    int   own;
    #1;
    b[0] = bus.req0 && bus.gnt0;
    b[1] = bus.req1 && bus.gnt1;
    check_bit("gnt_excl", bus.gnt0 && bus.gnt1, 1'b0);
    own = b[0] ? 0 : (b[1] ? 1 : -1);
    log_q.push_back(own);
    gnt_q.push_back({30'd0, bus.gnt1, bus.gnt0});
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    if (own >= 0) begin
      check_word("bram_addr", DATA_W'(bus.bram_addr), DATA_W'(caddr[own]));
      check_bit("bram_wr", bus.bram_wr, cwe[own]);
      if (cwe[own]) begin
        check_word("bram_din", bus.bram_din, cwd[own]);
        ref_mem[caddr[own]] = cwd[own];
      end else begin
        pend[own] = 1'b1;
        pdat[own] = ref_mem[caddr[own]];
      end
      if (own == 0 ? bus.req1 : bus.req0) run[own]++;
      else run[own] = 0;
      run[1 - own] = 0;
      check_bit("burst_limit", run[own] <= MAX_BURST, 1'b1);
    end else begin
      check_bit("nobeat_wr", bus.bram_wr, 1'b0);
    end
    @(posedge clk);
    #1;
    check_bit("rvld0", bus.rvld0, pend[0]);
    if (pend[0]) check_word("rdata0", bus.rdata0, pdat[0]);
    check_bit("rvld1", bus.rvld1, pend[1]);
    if (pend[1]) check_word("rdata1", bus.rdata1, pdat[1]);
    if (bus.rvld0) rv_q.push_back(0);
    if (bus.rvld1) rv_q.push_back(1);
    for (int r = 0; r < 2; r++) begin
      if (b[r]) begin
        left[r]--;
        new_op(r);
      end
    end
    apply();
  endtask

  task automatic run_until_done(input int bound, input string tag);
    int n;
    n = 0;
    while ((left[0] > 0 || left[1] > 0) && n < bound) begin
      cycle_step();
      n++;
    end
    check_bit({tag, "_done"}, (left[0] == 0 && left[1] == 0), 1'b1);
    left[0] = 0;
    left[1] = 0;
    apply();
    cycle_step();
  endtask

  task automatic clear_logs();
    log_q.delete();
    gnt_q.delete();
    rv_q.delete();
  endtask

  task automatic do_reset();
    left[0] = 0;
    left[1] = 0;
    run[0]  = 0;
    run[1]  = 0;
    new_op(0);
    new_op(1);
    apply();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    clear_logs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first1;
    int zeros;
    int cnt0;

    rd_only = 1'b0;
    wr_pct  = 40;

    // ---- reset state ----
    do_reset();
    check_bit("rst_gnt0", bus.gnt0, 1'b0);
    check_bit("rst_gnt1", bus.gnt1, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_rvld0", bus.rvld0, 1'b0);
    check_bit("rst_rvld1", bus.rvld1, 1'b0);
    check_bit("rst_wr", bus.bram_wr, 1'b0);

    // ---- single read of word 5 by requester 0 ----
    left[0] = 1; cwe[0] = 1'b0; caddr[0] = ADDR_W'(5);
    apply();
    #1;
    check_bit("t1_idle_gnt0", bus.gnt0, 1'b0);
    @(posedge clk); #1;
    check_bit("t1_gnt0", bus.gnt0, 1'b1);
    check_bit("t1_busy", bus.busy, 1'b1);
    check_word("t1_addr", DATA_W'(bus.bram_addr), 36'd5);
    check_bit("t1_wr", bus.bram_wr, 1'b0);
    @(posedge clk); #1;
    check_bit("t1_rvld0", bus.rvld0, 1'b1);
    check_word("t1_rdata0", bus.rdata0, 36'h1_2345_6789);
    check_bit("t1_rvld1", bus.rvld1, 1'b0);
    left[0] = 0;
    apply();
    @(posedge clk); #1;
    check_bit("t1_release", bus.gnt0, 1'b0);
    check_bit("t1_rvld_end", bus.rvld0, 1'b0);

    // ---- requester 1 writes then reads address 300 ----
    left[1] = 2; cwe[1] = 1'b1; caddr[1] = ADDR_W'(300); cwd[1] = 36'h0_000A_BCDE;
    apply();
    @(posedge clk); #1;
    check_bit("t2_gnt1", bus.gnt1, 1'b1);
    check_bit("t2_wr", bus.bram_wr, 1'b1);
    check_word("t2_addr", DATA_W'(bus.bram_addr), 36'd300);
    check_word("t2_din", bus.bram_din, 36'h0_000A_BCDE);
    ref_mem[300] = 36'h0_000A_BCDE;
    @(posedge clk); #1;
    cwe[1] = 1'b0;
    apply();
    #1;
    check_bit("t2_rd_wr", bus.bram_wr, 1'b0);
    check_bit("t2_no_rvld_wr", bus.rvld1, 1'b0);
    @(posedge clk); #1;
    check_bit("t2_rvld1", bus.rvld1, 1'b1);
    check_word("t2_rdata1", bus.rdata1, 36'h0_000A_BCDE);
    check_bit("t2_rvld0", bus.rvld0, 1'b0);
    left[1] = 0;
    apply();
    @(posedge clk); #1;
    check_bit("t2_idle", bus.busy, 1'b0);

    // ---- contention right after reset, streaming reads ----
    do_reset();
    rd_only = 1'b1;
    left[0] = 20; left[1] = 20;
    new_op(0); new_op(1);
    apply();
    run_until_done(200, "t3");
    first1 = -1; zeros = 0;
    foreach (log_q[i]) begin
      if (first1 < 0) begin
        if (log_q[i] == 1) first1 = i;
        else if (log_q[i] == 0) zeros++;
      end
    end
    check_int("t3_idle_first", log_q[0], -1);
    check_int("t3_own0_beats", zeros, MAX_BURST);
    check_int("t3_handover_idx", first1, MAX_BURST + 1);
    first1 = -1; zeros = 0;
    foreach (rv_q[i]) begin
      if (first1 < 0) begin
        if (rv_q[i] == 1) first1 = i;
        else zeros++;
      end
    end
    check_int("t3_rvld0_before_rvld1", zeros, MAX_BURST);

    // ---- uncontested long burst, then requester 1 arrives ----
    do_reset();
    left[0] = 45; left[1] = 0;
    new_op(0);
    apply();
    for (int k = 0; k < 41; k++) cycle_step();
    cnt0 = 0;
    foreach (log_q[i]) if (log_q[i] == 0) cnt0++;
    check_int("t4_long_beats", cnt0, 40);
    check_bit("t4_gnt0_held", bus.gnt0, 1'b1);
    clear_logs();
    left[1] = 5;
    new_op(1);
    apply();
    run_until_done(100, "t4");
    check_int("t4_one_more", log_q[0], 0);
    check_int("t4_then_gnt1", log_q[1], 1);

    // ---- early release by requester 1 while requester 0 waits ----
    do_reset();
    rd_only = 1'b0;
    left[1] = 3;
    new_op(1);
    apply();
    cycle_step();
    cycle_step();
    left[0] = 2;
    new_op(0);
    apply();
    run_until_done(50, "t5");
    check_int("t5_own1_nobeat", gnt_q[4], 2);
    check_int("t5_gnt0_next", gnt_q[5], 1);
    check_int("t5_beat0", log_q[5], 0);

    // last_owner follows releases: 0 releases, then 1 releases, then a tie
    do_reset();
    left[0] = 2; new_op(0); apply();
    run_until_done(20, "t5b");
    left[1] = 3; new_op(1); apply();
    run_until_done(20, "t5c");
    clear_logs();
    left[0] = 2; left[1] = 2; new_op(0); new_op(1); apply();
    run_until_done(40, "t5d");
    check_int("t5_tie_after_r1", log_q[1], 0);

    // ---- reset while a read beat is outstanding in OWN1 ----
    do_reset();
    rd_only = 1'b1;
    left[1] = 10;
    new_op(1);
    apply();
    cycle_step();
    cycle_step();
    cycle_step();
    reset = 1'b1;
    #1;
    check_bit("t6_gnt1", bus.gnt1, 1'b0);
    check_bit("t6_rvld1", bus.rvld1, 1'b0);
    check_bit("t6_wr", bus.bram_wr, 1'b0);
    check_bit("t6_busy", bus.busy, 1'b0);
    left[1] = 0;
    apply();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    run[0] = 0; run[1] = 0;
    clear_logs();
    #1;
    check_bit("t6_idle_busy", bus.busy, 1'b0);
    check_bit("t6_idle_gnt1", bus.gnt1, 1'b0);
    rd_only = 1'b0;
    left[0] = 3; left[1] = 3; new_op(0); new_op(1);
    apply();
    run_until_done(60, "t6");
    check_int("t6_first_idle", log_q[0], -1);
    check_int("t6_first_r0", log_q[1], 0);

    // ---- randomized mixed traffic ----
    wr_pct = 40;
    for (int rnd = 0; rnd < 8; rnd++) begin
      left[0] = $urandom_range(40, 0);
      left[1] = $urandom_range(40, 0);
      new_op(0); new_op(1);
      apply();
      run_until_done(400, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
